// File: rtl/mips_rf_pkg.sv
// rtl/mips_rf_pkg.sv - shared constants and helpers for the MIPS register file
//
// Purpose : default geometry of the general-purpose register file, the index
//           of the hard-wired zero register, and the address-width helper.
// Ports   : none (package).

package mips_rf_pkg;

   localparam int RF_DATA_W_DEF   = 32;
   localparam int RF_NUM_REGS_DEF = 32;
   localparam int REG_ZERO        = 0;

   function automatic int rf_addr_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits and pending-count tracker
//
// Purpose : owns the pending vector (register awaiting a result) and a
//           registered count of the set pending bits.
// Ports   : clk, reset       - clock, synchronous active-high reset
//           issue, issue_reg - mark issue_reg pending at the edge
//           reg_write, write_reg - result arrival, clears the pending bit
//           pending          - one bit per register
//           pending_cnt      - number of set pending bits (0..NUM_REGS)

module reg_scoreboard
   import mips_rf_pkg::*;
#(
   parameter int NUM_REGS = RF_NUM_REGS_DEF,
   parameter int ADDR_W   = rf_addr_w(NUM_REGS),
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                issue,
   input  logic [ADDR_W-1:0]   issue_reg,
   input  logic                reg_write,
   input  logic [ADDR_W-1:0]   write_reg,
   output logic [NUM_REGS-1:0] pending,
   output logic [ADDR_W:0]     pending_cnt
);

   logic                wr_en;
   logic                iss_en;
   logic                set_new;
   logic                clr_old;
   logic [NUM_REGS-1:0] pending_nxt;

   always_comb begin
      wr_en  = reg_write && !(ZERO_REG && (write_reg == ADDR_W'(REG_ZERO)));
      iss_en = issue     && !(ZERO_REG && (issue_reg == ADDR_W'(REG_ZERO)));

      // Issue is applied after the write clear so that a same-register
      // collision leaves the bit set: the issuing instruction is younger.
      pending_nxt = pending;
      if (wr_en) begin
         pending_nxt[write_reg] = 1'b0;
      end
      if (iss_en) begin
         pending_nxt[issue_reg] = 1'b1;
      end
      if (ZERO_REG) begin
         pending_nxt[0] = 1'b0;
      end

      // Count only real transitions of a bit; re-issuing a pending register
      // or writing an idle one leaves the count untouched.
      set_new = iss_en && !pending[issue_reg];
      clr_old = wr_en && pending[write_reg] && !(iss_en && (issue_reg == write_reg));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending     <= '0;
         pending_cnt <= '0;
      end else begin
         pending <= pending_nxt;
         case ({set_new, clr_old})
            2'b10:   pending_cnt <= pending_cnt + (ADDR_W+1)'(1);
            2'b01:   pending_cnt <= pending_cnt - (ADDR_W+1)'(1);
            default: pending_cnt <= pending_cnt;
         endcase
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with pending scoreboard, bypass and debug port
//
// Purpose : NUM_REGS x DATA_W general-purpose registers for the MIPS cores,
//           NUM_RD combinational read ports with write-to-read forwarding,
//           pending tracking for issued destinations, and a raw debug read.
// Ports   : clk, reset          - clock, synchronous active-high reset
//           reg_write, write_reg, write_data - writeback port
//           read_reg, read_data, read_valid  - packed read ports
//           issue, issue_reg    - mark a destination pending
//           pending_cnt         - number of pending registers
//           dbg_reg, dbg_data   - raw array read, never bypassed

module reg_file_sb
   import mips_rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W_DEF,
   parameter int NUM_REGS = RF_NUM_REGS_DEF,
   parameter int ADDR_W   = rf_addr_w(NUM_REGS),  // derived, leave at default
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     reg_write,
   input  logic [ADDR_W-1:0]        write_reg,
   input  logic [DATA_W-1:0]        write_data,
   input  logic [NUM_RD*ADDR_W-1:0] read_reg,
   output logic [NUM_RD*DATA_W-1:0] read_data,
   output logic [NUM_RD-1:0]        read_valid,
   input  logic                     issue,
   input  logic [ADDR_W-1:0]        issue_reg,
   output logic [ADDR_W:0]          pending_cnt,
   input  logic [ADDR_W-1:0]        dbg_reg,
   output logic [DATA_W-1:0]        dbg_data
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic                wr_en;

   assign wr_en = reg_write && !(ZERO_REG && (write_reg == ADDR_W'(REG_ZERO)));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[write_reg] <= write_data;
      end
   end

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .issue       (issue),
      .issue_reg   (issue_reg),
      .reg_write   (reg_write),
      .write_reg   (write_reg),
      .pending     (pending),
      .pending_cnt (pending_cnt)
   );

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] rd_d;
      logic              rd_v;

      assign addr = read_reg[gi*ADDR_W +: ADDR_W];

      // The zero check comes first so a dropped write to r0 is never
      // forwarded onto a port reading r0.
      always_comb begin
         rd_d = regs[addr];
         rd_v = ~pending[addr];
         if (ZERO_REG && (addr == ADDR_W'(REG_ZERO))) begin
            rd_d = '0;
            rd_v = 1'b1;
         end else if (BYPASS && reg_write && (write_reg == addr)) begin
            rd_d = write_data;
            rd_v = 1'b1;
         end
      end

      assign read_data[gi*DATA_W +: DATA_W] = rd_d;
      assign read_valid[gi]                 = rd_v;
   end

   assign dbg_data = regs[dbg_reg];

endmodule
